serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial, LSB-first N-bit subtractor built around a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion to the team's full-adder datapath. It accepts two operands plus a borrow-in through a valid/ready handshake and shifts them through the cell one bit per clock. It then holds the difference and borrow-out under a second valid/ready handshake until they are consumed.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the block has one clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start_valid  input  1  operands present on a, b, borrowin.
- start_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend, unsigned (two's complement for overflow).
- b  input  WIDTH  subtrahend.
- borrowin  input  1  borrow into bit 0.
- diff  output  WIDTH  (a - b - borrowin) mod 2^WIDTH.
- borrowout  output  1  1 iff a < b + borrowin (unsigned).
- done_valid  output  1  diff/borrowout valid.
- done_ready  input  1  consumer accepts result.
- busy  output  1  high in SHIFT.
- overflow  output  1  signed overflow; present only with SERIAL_SUB_OVERFLOW_EN.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start_ready=1. On start_valid & start_ready, the block does the following at that edge, then goes to SHIFT:
  - loads a, b into shift registers;
  - sets borrow flop to borrowin;
  - clears the bit counter.
- SHIFT, per cycle:
  - cell computes d = a0 ^ b0 ^ bq and bnext = (~a0 & b0) | (~(a0 ^ b0) & bq);
  - d shifts into the diff register MSB, operands shift right, borrow flop takes bnext, counter increments.
- After WIDTH SHIFT cycles the block goes to DONE. borrowout equals the final borrow flop value.
- DONE: done_valid=1; diff, borrowout, overflow held stable. On done_ready the block goes to IDLE. start_valid is ignored in DONE.
- Inputs a/b/borrowin are sampled only on the accepting edge; later changes have no effect.
- Counter width is $clog2(WIDTH+1). No arithmetic wider than WIDTH+1.

## Timing
- Reset (async assert): state=IDLE, with these output values:
  - start_ready=1, busy=0, done_valid=0;
  - diff=0, borrowout=0, overflow=0.
- Latency: done_valid rises exactly WIDTH rising edges after the accepting edge (8 for default).
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH shifts, one DONE cycle with done_ready already high).
- DONE→IDLE takes one edge. No same-cycle accept on DONE exit.
- Reset mid-SHIFT or mid-DONE: operation aborted with no result produced. Post-reset values are as above.
- done_ready low indefinitely: the block stays in DONE with outputs frozen.

## Configuration
- SERIAL_SUB_OVERFLOW_EN defined:
  - overflow port exists;
  - it is registered at entry to DONE as (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched a/b MSBs;
  - reset value is 0, and it is cleared on the next accept.
- SERIAL_SUB_OVERFLOW_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package serial_sub_pkg holds the state enum typedef (IDLE/SHIFT/DONE) and the default width constant.
- One sub-module: full_subtractor (combinational; inputs a, b, borrowin; outputs diff, borrowout), built structurally from gates in the same style as the existing full adder.

## Test plan
- Reset: assert rst_n=0 mid-idle → all outputs at reset values; after release, start_ready=1 and busy=0.
- Basic: a=0x5A, b=0x1F, borrowin=0 → diff=0x3B, borrowout=0, done_valid exactly 8 edges after accept.
- Wrap and borrow:
  - a=0x00, b=0x01, borrowin=0 → diff=0xFF, borrowout=1;
  - a=0x00, b=0xFF, borrowin=1 → diff=0x00, borrowout=1.
- Overflow (macro defined):
  - a=0x80, b=0x01 → diff=0x7F, overflow=1, borrowout=0;
  - a=0x7F, b=0xFF → diff=0x80, overflow=1, borrowout=1;
  - a=0x10, b=0x05 → overflow=0.
- Backpressure: hold done_ready=0 for 5 cycles with start_valid=1 → diff/borrowout stable and start_ready=0 throughout; raise done_ready → IDLE next edge, start_ready=1.
- Reset mid-SHIFT: assert rst_n=0 after 3 shift cycles → immediate reset values; next operation a=0xC3, b=0x3C → diff=0x87, borrowout=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// State encoding plus the default operand width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The overflow wire only exists when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrowin;
    logic [WIDTH-1:0] diff;
    logic             borrowout;
    logic             done_valid;
    logic             done_ready;
    logic             busy;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;
`endif

    modport master (
        output start_valid, a, b, borrowin, done_ready,
`ifdef SERIAL_SUB_OVERFLOW_EN
        input  overflow,
`endif
        input  start_ready, diff, borrowout, done_valid, busy
    );

    modport slave (
        input  start_valid, a, b, borrowin, done_ready,
`ifdef SERIAL_SUB_OVERFLOW_EN
        output overflow,
`endif
        output start_ready, diff, borrowout, done_valid, busy
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from gate primitives.
// Latency: combinational. Backpressure: none.
// Borrow is generated when a=0,b=1, or propagated when a==b.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrowin,
    output logic diff,
    output logic borrowout
);
    logic ab_x, a_n, ab_xn, gen, prop;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (diff, ab_x, borrowin);
    not g_n0 (a_n, a);
    not g_n1 (ab_xn, ab_x);
    and g_a0 (gen, a_n, b);
    and g_a1 (prop, ab_xn, borrowin);
    or  g_o0 (borrowout, gen, prop);

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial subtractor: a - b - borrowin through one full-subtractor cell.
// Latency: done_valid rises WIDTH edges after the accepting edge.
// Backpressure: result held in DONE until done_ready; start_ready only in IDLE. Optional overflow via SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_subtractor_if.slave io
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, diff_q;
    logic [CW-1:0]    cnt;
    logic             bq, d, bnext;
    logic             accept, last, idle, shifting, holding;

    full_subtractor u_cell (
        .a         (a_sh[0]),
        .b         (b_sh[0]),
        .borrowin  (bq),
        .diff      (d),
        .borrowout (bnext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        idle      = 1'b0;
        shifting  = 1'b0;
        holding   = 1'b0;
        case (state)
            IDLE: begin
                idle = 1'b1;
                if (io.start_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shifting = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                holding = 1'b1;
                // start_valid is deliberately ignored here: exit always lands in IDLE first.
                if (io.done_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            diff_q <= '0;
            bq     <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh <= io.a;
            b_sh <= io.b;
            bq   <= io.borrowin;
            cnt  <= '0;
        end else if (shifting) begin
            diff_q <= {d, diff_q[WIDTH-1:1]};
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            bq     <= bnext;
            cnt    <= cnt + CW'(1);
        end
    end

    assign io.start_ready = idle;
    assign io.busy        = shifting;
    assign io.done_valid  = holding;
    assign io.diff        = diff_q;
    assign io.borrowout   = bq;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb, b_msb, ov_q;

    // Operand MSBs are kept aside because the shift registers are consumed by the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ov_q  <= 1'b0;
        end else if (accept) begin
            a_msb <= io.a[WIDTH-1];
            b_msb <= io.b[WIDTH-1];
            ov_q  <= 1'b0;
        end else if (last) begin
            ov_q  <= (a_msb ^ b_msb) & (d ^ a_msb);
        end
    end

    assign io.overflow = ov_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus randomized bench for serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [W-1:0] exp_diff;
    logic         exp_bo;
    logic         exp_ov;

    serial_subtractor_if #(.WIDTH(W)) io ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin);
        int res;
        res      = int'(av) - int'(bv) - int'(bin);
        exp_diff = W'(res);
        exp_bo   = (res < 0);
        exp_ov   = (av[W-1] != bv[W-1]) && (exp_diff[W-1] != av[W-1]);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_start_ready"}, 64'(io.start_ready), 64'd1);
        check({tag, "_busy"},        64'(io.busy),        64'd0);
        check({tag, "_done_valid"},  64'(io.done_valid),  64'd0);
        check({tag, "_diff"},        64'(io.diff),        64'd0);
        check({tag, "_borrowout"},   64'(io.borrowout),   64'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({tag, "_overflow"},    64'(io.overflow),    64'd0);
`endif
    endtask

    // Issues one operation and leaves the block in DONE with done_ready low.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin);
        int edges;
        model(av, bv, bin);
        @(negedge clk);
        io.a           = av;
        io.b           = bv;
        io.borrowin    = bin;
        io.start_valid = 1'b1;
        io.done_ready  = 1'b0;
        check({tag, "_ready_before_accept"}, 64'(io.start_ready), 64'd1);
        @(posedge clk);
        #1;
        io.start_valid = 1'b0;
        io.a           = W'($urandom);
        io.b           = W'($urandom);
        io.borrowin    = 1'($urandom);
        check({tag, "_busy_after_accept"}, 64'(io.busy), 64'd1);
        edges = 0;
        while (!io.done_valid && edges < 4 * W) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_latency"},   64'(edges),        64'(W));
        check({tag, "_diff"},      64'(io.diff),      64'(exp_diff));
        check({tag, "_borrowout"}, 64'(io.borrowout), 64'(exp_bo));
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({tag, "_overflow"},  64'(io.overflow),  64'(exp_ov));
`endif
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk);
        io.done_ready = 1'b1;
        @(posedge clk);
        #1;
        io.done_ready = 1'b0;
        check({tag, "_exit_start_ready"}, 64'(io.start_ready), 64'd1);
        check({tag, "_exit_done_valid"},  64'(io.done_valid),  64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rbin;

        rst_n          = 1'b0;
        io.start_valid = 1'b0;
        io.a           = '0;
        io.b           = '0;
        io.borrowin    = 1'b0;
        io.done_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while idle
        rst_n = 1'b0;
        #1;
        check_reset_vals("idle_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_rst_rel_ready", 64'(io.start_ready), 64'd1);
        check("idle_rst_rel_busy",  64'(io.busy),        64'd0);

        run_op("basic", 8'h5A, 8'h1F, 1'b0);
        finish_op("basic");
        run_op("wrap1", 8'h00, 8'h01, 1'b0);
        finish_op("wrap1");
        run_op("wrap2", 8'h00, 8'hFF, 1'b1);
        finish_op("wrap2");
        run_op("ovf1", 8'h80, 8'h01, 1'b0);
        finish_op("ovf1");
        run_op("ovf2", 8'h7F, 8'hFF, 1'b0);
        finish_op("ovf2");
        run_op("ovf3", 8'h10, 8'h05, 1'b0);
        finish_op("ovf3");

        // Backpressure: DONE held while start_valid pulses with fresh operands
        run_op("bp", 8'hA5, 8'h3C, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            io.start_valid = 1'b1;
            io.a           = W'($urandom);
            io.b           = W'($urandom);
            @(posedge clk);
            #1;
            check("bp_diff",        64'(io.diff),        64'(exp_diff));
            check("bp_borrowout",   64'(io.borrowout),   64'(exp_bo));
            check("bp_start_ready", 64'(io.start_ready), 64'd0);
            check("bp_done_valid",  64'(io.done_valid),  64'd1);
        end
        @(negedge clk);
        io.done_ready = 1'b1;
        @(posedge clk);
        #1;
        io.done_ready  = 1'b0;
        io.start_valid = 1'b0;
        check("bp_exit_start_ready", 64'(io.start_ready), 64'd1);
        check("bp_exit_busy",        64'(io.busy),        64'd0);

        // Reset in the middle of shifting
        @(negedge clk);
        io.a           = 8'h12;
        io.b           = 8'h34;
        io.borrowin    = 1'b0;
        io.start_valid = 1'b1;
        @(posedge clk);
        #1;
        io.start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("shift_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 8'hC3, 8'h3C, 1'b0);
        finish_op("post_rst");

        for (int i = 0; i < 20; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            run_op("rand", ra, rb, rbin);
            finish_op("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog");
    end

endmodule
